// File: rtl/crossbar_fifo.sv
// rtl/crossbar_fifo.sv - per-input word queue for the crossbar
module crossbar_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             accept_en;
    logic             push;
    logic             pop;

    assign s_tready = accept_en && (count != CNT_W'(DEPTH));
    assign m_tvalid = (count != '0);
    assign m_tdata  = mem[rd_ptr];
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            accept_en <= 1'b0;
        end else begin
            accept_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end
endmodule

// File: rtl/crossbar_nxn.sv
// rtl/crossbar_nxn.sv - N x N crossbar with input queues and round-robin output arbiters
module crossbar_nxn #(
    parameter int WIDTH = 320,
    parameter int DEPTH = 128,
    parameter int PORTS = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORTS*WIDTH-1:0]           in_data,
    input  logic [PORTS*$clog2(PORTS)-1:0]   in_dst,
    input  logic [PORTS-1:0]                 in_valid,
    output logic [PORTS-1:0]                 in_ready,
    output logic [PORTS*WIDTH-1:0]           out_data,
    output logic [PORTS*$clog2(PORTS)-1:0]   out_src,
    output logic [PORTS-1:0]                 out_valid,
    input  logic [PORTS-1:0]                 out_ready
);
    localparam int SEL_W = $clog2(PORTS);
    localparam int ENT_W = WIDTH + SEL_W;

    logic [WIDTH-1:0] head_data  [PORTS];
    logic [SEL_W-1:0] head_dst   [PORTS];
    logic [PORTS-1:0] head_valid;
    logic [PORTS-1:0] pop;

    logic [PORTS-1:0] gnt_valid;
    logic [SEL_W-1:0] gnt_idx    [PORTS];
    logic [SEL_W-1:0] last_grant [PORTS];
    logic [SEL_W-1:0] idx;

    logic [WIDTH-1:0] od_r [PORTS];
    logic [SEL_W-1:0] os_r [PORTS];
    logic [PORTS-1:0] ov_r;

    genvar p;
    generate
        for (p = 0; p < PORTS; p++) begin : g_port
            logic [ENT_W-1:0] head;

            crossbar_fifo #(
                .WIDTH(ENT_W),
                .DEPTH(DEPTH)
            ) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .s_tdata  ({in_data[p*WIDTH +: WIDTH], in_dst[p*SEL_W +: SEL_W]}),
                .s_tvalid (in_valid[p]),
                .s_tready (in_ready[p]),
                .m_tdata  (head),
                .m_tvalid (head_valid[p]),
                .m_tready (pop[p])
            );

            assign head_data[p]                = head[ENT_W-1:SEL_W];
            assign head_dst[p]                 = head[SEL_W-1:0];
            assign out_data[p*WIDTH +: WIDTH]  = od_r[p];
            assign out_src[p*SEL_W +: SEL_W]   = os_r[p];
        end
    endgenerate

    assign out_valid = ov_r;

    always_comb begin
        gnt_valid = '0;
        pop       = '0;
        idx       = '0;
        for (int q = 0; q < PORTS; q++) begin
            gnt_idx[q] = '0;
            if (!ov_r[q] || out_ready[q]) begin
                for (int i = 1; i <= PORTS; i++) begin
                    idx = last_grant[q] + SEL_W'(i);
                    if (!gnt_valid[q] && head_valid[idx] && (head_dst[idx] == SEL_W'(q))) begin
                        gnt_valid[q] = 1'b1;
                        gnt_idx[q]   = idx;
                    end
                end
            end
            if (gnt_valid[q]) begin
                pop[gnt_idx[q]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int q = 0; q < PORTS; q++) begin
                od_r[q]       <= '0;
                os_r[q]       <= '0;
                last_grant[q] <= SEL_W'(PORTS - 1);
            end
            ov_r <= '0;
        end else begin
            for (int q = 0; q < PORTS; q++) begin
                if (gnt_valid[q]) begin
                    od_r[q]       <= head_data[gnt_idx[q]];
                    os_r[q]       <= gnt_idx[q];
                    ov_r[q]       <= 1'b1;
                    last_grant[q] <= gnt_idx[q];
                end else if (out_ready[q]) begin
                    ov_r[q] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_crossbar_nxn.sv
// tb/tb_crossbar_nxn.sv - self-checking bench for crossbar_nxn
module tb_crossbar_nxn;
    localparam int P = 4;
    localparam int W = 8;
    localparam int D = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [P*W-1:0] in_data;
    logic [P*S-1:0] in_dst;
    logic [P-1:0]   in_valid;
    logic [P-1:0]   in_ready;
    logic [P*W-1:0] out_data;
    logic [P*S-1:0] out_src;
    logic [P-1:0]   out_valid;
    logic [P-1:0]   out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] sb [16][$];

    always #5 clk = ~clk;

    crossbar_nxn #(
        .WIDTH(W),
        .DEPTH(D),
        .PORTS(P)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_dst    (in_dst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic logic [W-1:0] od(input int q);
        return out_data[q*W +: W];
    endfunction

    function automatic logic [S-1:0] os(input int q);
        return out_src[q*S +: S];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [W-1:0] d, input logic [S-1:0] dst);
        in_data[p*W +: W] = d;
        in_dst[p*S +: S]  = dst;
    endtask

    task automatic drain();
        in_valid  = '0;
        out_ready = '1;
        repeat (8) step();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        in_data   = '0;
        in_dst    = '0;
        #2;
        rst = 1'b0;
        repeat (2) step();
        n_checks++;
        if (in_ready !== 4'h0) $display("FAIL reset_in_ready: got %b want %b", in_ready, 4'h0); else n_pass++;
        n_checks++;
        if (out_valid !== 4'h0) $display("FAIL reset_out_valid: got %b want %b", out_valid, 4'h0); else n_pass++;
        n_checks++;
        if ({out_data, out_src} !== 40'h0) $display("FAIL reset_out_data_src: got %h want %h", {out_data, out_src}, 40'h0); else n_pass++;
        rst = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 4'hF) $display("FAIL release_in_ready: got %b want %b", in_ready, 4'hF); else n_pass++;
    endtask

    task automatic test_single();
        out_ready = 4'hF;
        drive(0, 8'hA5, 2'd2);
        in_valid = 4'b0001;
        step();
        in_valid = '0;
        n_checks++;
        if (out_valid !== 4'h0) $display("FAIL single_early: got %b want %b", out_valid, 4'h0); else n_pass++;
        step();
        n_checks++;
        if ({out_valid, od(2), os(2)} !== {4'b0100, 8'hA5, 2'd0})
            $display("FAIL single_deliver: got %h want %h", {out_valid, od(2), os(2)}, {4'b0100, 8'hA5, 2'd0});
        else n_pass++;
        step();
        n_checks++;
        if (out_valid !== 4'h0) $display("FAIL single_clear: got %b want %b", out_valid, 4'h0); else n_pass++;
        drain();
    endtask

    task automatic test_round_robin();
        int sent [4];
        int got;
        logic [3:0] acc;
        logic [10:0] obs;
        logic [10:0] exp_v;
        for (int p = 0; p < 4; p++) sent[p] = 0;
        got       = 0;
        out_ready = 4'hF;
        for (int c = 0; c < 20; c++) begin
            for (int p = 0; p < 4; p++) begin
                in_valid[p] = (sent[p] < 3);
                drive(p, 8'(p * 16 + sent[p]), 2'd1);
            end
            acc = in_valid & in_ready;
            step();
            for (int p = 0; p < 4; p++) if (acc[p]) sent[p]++;
            if ((out_valid[1] || got > 0) && got < 12) begin
                exp_v = {1'b1, 2'(got % 4), 8'((got % 4) * 16 + got / 4)};
                obs   = {out_valid[1], os(1), od(1)};
                n_checks++;
                if (obs !== exp_v) $display("FAIL rr_word%0d: got %h want %h", got, obs, exp_v); else n_pass++;
                got++;
            end
        end
        in_valid = '0;
        n_checks++;
        if (got !== 12) $display("FAIL rr_count: got %0d want %0d", got, 12); else n_pass++;
        drain();
    endtask

    task automatic test_backpressure();
        int n_acc;
        int n_got;
        logic acc;
        logic fire;
        logic [7:0] val;
        out_ready = 4'b0111;
        n_acc     = 0;
        for (int g = 0; g < 12 && n_acc < 5; g++) begin
            in_valid = 4'b0010;
            drive(1, 8'(8'h10 + n_acc), 2'd3);
            acc = in_ready[1];
            step();
            if (acc) n_acc++;
        end
        in_valid = '0;
        n_checks++;
        if (n_acc !== 5) $display("FAIL bp_accepted: got %0d want %0d", n_acc, 5); else n_pass++;
        n_checks++;
        if (in_ready[1] !== 1'b0) $display("FAIL bp_full: got %b want %b", in_ready[1], 1'b0); else n_pass++;
        n_checks++;
        if ({out_valid[3], od(3), os(3)} !== {1'b1, 8'h10, 2'd1})
            $display("FAIL bp_held: got %h want %h", {out_valid[3], od(3), os(3)}, {1'b1, 8'h10, 2'd1});
        else n_pass++;
        repeat (3) step();
        n_checks++;
        if ({out_valid[3], od(3), os(3)} !== {1'b1, 8'h10, 2'd1})
            $display("FAIL bp_stable: got %h want %h", {out_valid[3], od(3), os(3)}, {1'b1, 8'h10, 2'd1});
        else n_pass++;
        out_ready = 4'hF;
        n_got     = 0;
        for (int g = 0; g < 12 && n_got < 5; g++) begin
            fire = out_valid[3] & out_ready[3];
            val  = od(3);
            step();
            if (fire) begin
                n_checks++;
                if (val !== 8'(8'h10 + n_got)) $display("FAIL bp_order%0d: got %h want %h", n_got, val, 8'(8'h10 + n_got)); else n_pass++;
                n_got++;
            end
            if (g == 0) begin
                n_checks++;
                if (in_ready[1] !== 1'b1) $display("FAIL bp_reopen: got %b want %b", in_ready[1], 1'b1); else n_pass++;
            end
        end
        n_checks++;
        if (n_got !== 5) $display("FAIL bp_drained: got %0d want %0d", n_got, 5); else n_pass++;
        drain();
    endtask

    task automatic test_hol();
        logic [7:0] wd [3];
        logic [1:0] wt [3];
        int n_acc;
        logic acc;
        wd[0] = 8'h21; wt[0] = 2'd2;
        wd[1] = 8'h22; wt[1] = 2'd2;
        wd[2] = 8'h23; wt[2] = 2'd0;
        out_ready = 4'b1011;
        n_acc     = 0;
        for (int g = 0; g < 10 && n_acc < 3; g++) begin
            in_valid = 4'b0001;
            drive(0, wd[n_acc], wt[n_acc]);
            acc = in_ready[0];
            step();
            if (acc) n_acc++;
        end
        in_valid = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++;
            if ({out_valid[0], out_valid[2], od(2)} !== {1'b0, 1'b1, 8'h21})
                $display("FAIL hol_blocked%0d: got %h want %h", c, {out_valid[0], out_valid[2], od(2)}, {1'b0, 1'b1, 8'h21});
            else n_pass++;
        end
        out_ready = 4'hF;
        step();
        n_checks++;
        if ({out_valid[0], od(2)} !== {1'b0, 8'h22})
            $display("FAIL hol_second: got %h want %h", {out_valid[0], od(2)}, {1'b0, 8'h22});
        else n_pass++;
        step();
        n_checks++;
        if ({out_valid[0], od(0), os(0)} !== {1'b1, 8'h23, 2'd0})
            $display("FAIL hol_release: got %h want %h", {out_valid[0], od(0), os(0)}, {1'b1, 8'h23, 2'd0});
        else n_pass++;
        drain();
    endtask

    task automatic test_permutation();
        int p;
        out_ready = 4'hF;
        for (int s = 1; s <= 13; s++) begin
            in_valid = (s <= 12) ? 4'hF : 4'h0;
            for (int i = 0; i < 4; i++) drive(i, 8'(i * 64 + s - 1), 2'((i + 1) % 4));
            step();
            n_checks++;
            if (in_ready !== 4'hF) $display("FAIL perm_ready%0d: got %b want %b", s, in_ready, 4'hF); else n_pass++;
            if (s >= 2) begin
                for (int q = 0; q < 4; q++) begin
                    p = (q + 3) % 4;
                    n_checks++;
                    if ({out_valid[q], os(q), od(q)} !== {1'b1, 2'(p), 8'(p * 64 + s - 2)})
                        $display("FAIL perm_out%0d_cyc%0d: got %h want %h", q, s, {out_valid[q], os(q), od(q)}, {1'b1, 2'(p), 8'(p * 64 + s - 2)});
                    else n_pass++;
                end
            end
        end
        drain();
    endtask

    task automatic test_random();
        logic [3:0] acc;
        logic [3:0] fire;
        logic [3:0] hold;
        logic [7:0] hd [4];
        logic [1:0] hs [4];
        int n_in;
        int n_out;
        int k;
        int left;
        n_in     = 0;
        n_out    = 0;
        in_valid = '0;
        for (int c = 0; c < 640; c++) begin
            if (c < 600) begin
                for (int p = 0; p < 4; p++) begin
                    if (!in_valid[p] && $urandom_range(0, 3) != 0) begin
                        in_valid[p] = 1'b1;
                        drive(p, 8'($urandom), 2'($urandom));
                    end
                    out_ready[p] = ($urandom_range(0, 3) != 0);
                end
            end else begin
                in_valid  = '0;
                out_ready = 4'hF;
            end
            acc  = in_valid & in_ready;
            fire = out_valid & out_ready;
            hold = out_valid & ~out_ready;
            for (int q = 0; q < 4; q++) begin
                hd[q] = od(q);
                hs[q] = os(q);
            end
            for (int p = 0; p < 4; p++) begin
                if (acc[p]) begin
                    sb[p * 4 + int'(in_dst[p*S +: S])].push_back(in_data[p*W +: W]);
                    n_in++;
                end
            end
            for (int q = 0; q < 4; q++) begin
                if (fire[q]) begin
                    k = int'(hs[q]) * 4 + q;
                    n_checks++;
                    if (sb[k].size() == 0) begin
                        $display("FAIL rand_unexpected: out%0d got %h from in%0d, none outstanding", q, hd[q], hs[q]);
                    end else begin
                        if (hd[q] !== sb[k][0]) $display("FAIL rand_order: out%0d in%0d got %h want %h", q, hs[q], hd[q], sb[k][0]); else n_pass++;
                        void'(sb[k].pop_front());
                    end
                    n_out++;
                end
            end
            step();
            for (int p = 0; p < 4; p++) if (acc[p]) in_valid[p] = 1'b0;
            for (int q = 0; q < 4; q++) begin
                if (hold[q]) begin
                    n_checks++;
                    if ({out_valid[q], od(q), os(q)} !== {1'b1, hd[q], hs[q]})
                        $display("FAIL rand_hold: out%0d got %h want %h", q, {out_valid[q], od(q), os(q)}, {1'b1, hd[q], hs[q]});
                    else n_pass++;
                end
            end
        end
        left = 0;
        for (int i = 0; i < 16; i++) left += sb[i].size();
        n_checks++;
        if (left !== 0 || n_out !== n_in) $display("FAIL rand_conserve: got %0d delivered %0d outstanding, want %0d delivered 0 outstanding", n_out, left, n_in);
        else n_pass++;
        n_checks++;
        if (n_in < 200) $display("FAIL rand_traffic: got %0d accepted want at least %0d", n_in, 200); else n_pass++;
        drain();
    endtask

    task automatic test_reset_mid();
        int sent [4];
        logic [3:0] acc;
        for (int p = 0; p < 4; p++) sent[p] = 0;
        out_ready = '0;
        for (int g = 0; g < 10; g++) begin
            for (int p = 0; p < 4; p++) begin
                in_valid[p] = (sent[p] < 2);
                drive(p, 8'(8'hE0 + p * 2 + sent[p]), 2'd0);
            end
            acc = in_valid & in_ready;
            step();
            for (int p = 0; p < 4; p++) if (acc[p]) sent[p]++;
        end
        in_valid = '0;
        n_checks++;
        if (out_valid[0] !== 1'b1) $display("FAIL rm_loaded: got %b want %b", out_valid[0], 1'b1); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 8'h00) $display("FAIL rm_async_clear: got %h want %h", {out_valid, in_ready}, 8'h00); else n_pass++;
        #2;
        rst = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 4'hF) $display("FAIL rm_ready: got %b want %b", in_ready, 4'hF); else n_pass++;
        out_ready = 4'hF;
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++;
            if (out_valid !== 4'h0) $display("FAIL rm_stale%0d: got %b want %b", c, out_valid, 4'h0); else n_pass++;
        end
        for (int p = 0; p < 4; p++) drive(p, 8'(8'h70 + p), 2'd2);
        in_valid = 4'hF;
        step();
        in_valid = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({out_valid[2], os(2), od(2)} !== {1'b1, 2'(i), 8'(8'h70 + i)})
                $display("FAIL rm_grant%0d: got %h want %h", i, {out_valid[2], os(2), od(2)}, {1'b1, 2'(i), 8'(8'h70 + i)});
            else n_pass++;
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d/%0d checks done", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_hol();
        test_permutation();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
